// File: rtl/enable_wrap_counter_pkg.sv
// Package: enable_wrap_counter_pkg
// Purpose: width helper for enable_wrap_counter. Surrounding logic can use it
//          to size buses that carry counter_val_o, starting from the same
//          MAX_COUNTER_VALUE.
package enable_wrap_counter_pkg;

  // Returns the number of bits needed to hold every value 0..max_value.
  function automatic int counter_width(input int max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/enable_wrap_counter.sv
// Module: enable_wrap_counter
// Purpose: parameterised up-counter. It counts enabled clock cycles from 0 to
//          MAX_COUNTER_VALUE and flags the terminal count on finished_o.
//          Typical uses are timeouts and frame dividers inside control blocks.
//
// Configuration macro: COUNTER_SATURATE_EN
//   undefined (default): an enabled edge at MAX_COUNTER_VALUE wraps to 0.
//   defined            : an enabled edge at MAX_COUNTER_VALUE holds at MAX.
//
// Ports:
//   clock_i        in   1  system clock; all state updates on the rising edge
//   reset_i        in   1  synchronous, active-high reset; overrides enable_i
//   enable_i       in   1  count enable, sampled on the rising edge
//   finished_o     out  1  high while the count equals MAX_COUNTER_VALUE
//   counter_val_o  out  W  current count, W = clog2(MAX_COUNTER_VALUE + 1)
module enable_wrap_counter
  import enable_wrap_counter_pkg::*;
#(
  parameter int MAX_COUNTER_VALUE = 33,
  localparam int W = counter_width(MAX_COUNTER_VALUE)
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         enable_i,
  output logic         finished_o,
  output logic [W-1:0] counter_val_o
);

  localparam logic [W-1:0] MAX_W = W'(MAX_COUNTER_VALUE);

  logic [W-1:0] count_p0;
  logic [W-1:0] count_nxt;
  logic         at_max;

  // The terminal compare is taken from the registered count. finished_o
  // therefore lines up with counter_val_o and carries no input-to-output path.
  assign at_max = (count_p0 == MAX_W);

  always_comb begin
    count_nxt = count_p0;
    if (enable_i) begin
      if (at_max) begin
`ifdef COUNTER_SATURATE_EN
        count_nxt = MAX_W;
`else
        count_nxt = '0;
`endif
      end else begin
        count_nxt = count_p0 + W'(1);
      end
    end
  end

  // Stage p0: count register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_p0 <= '0;
    end else begin
      count_p0 <= count_nxt;
    end
  end

  assign counter_val_o = count_p0;
  assign finished_o    = at_max;

endmodule

// File: tb/tb_enable_wrap_counter.sv
module tb_enable_wrap_counter;

  localparam int MAX  = 33;
  localparam int W0   = $clog2(MAX + 1);

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, rst1, en1;
  logic [W0-1:0] cnt;
  logic          fin;
  logic [0:0]    cnt1;
  logic          fin1;

  always #5 clk = ~clk;

  enable_wrap_counter #(.MAX_COUNTER_VALUE(MAX)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .enable_i     (en),
    .finished_o   (fin),
    .counter_val_o(cnt)
  );

  enable_wrap_counter #(.MAX_COUNTER_VALUE(1)) dut1 (
    .clock_i      (clk),
    .reset_i      (rst1),
    .enable_i     (en1),
    .finished_o   (fin1),
    .counter_val_o(cnt1)
  );

  typedef struct {
    int c;
    bit f;
    int c1;
    bit f1;
  } exp_t;

  exp_t q[$];
  int   m, m1;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int next_count(input int cur, input bit r, input bit e, input int mx);
    if (r) return 0;
    if (!e) return cur;
    if (cur == mx) return SAT ? mx : 0;
    return cur + 1;
  endfunction

  // Drive one clock's inputs, queue the expected outputs, then compare them
  // once the edge has been taken.
  task automatic cycle(input bit r, input bit e, input bit r1, input bit e1);
    exp_t x;
    rst  = r;
    en   = e;
    rst1 = r1;
    en1  = e1;
    m  = next_count(m, r, e, MAX);
    m1 = next_count(m1, r1, e1, 1);
    x.c  = m;
    x.f  = (m == MAX);
    x.c1 = m1;
    x.f1 = (m1 == 1);
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    check_val("cnt", 32'(cnt), 32'(x.c));
    check_val("fin", 32'(fin), 32'(x.f));
    check_val("cnt1", 32'(cnt1), 32'(x.c1));
    check_val("fin1", 32'(fin1), 32'(x.f1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    m = 0; m1 = 0;
    rst = 1'b1; en = 1'b1; rst1 = 1'b1; en1 = 1'b1;
    @(negedge clk);

    // 1. reset held with enable high
    repeat (2) begin
      cycle(1, 1, 1, 1);
      check_val("t1_rst_cnt", 32'(cnt), 0);
      check_val("t1_rst_fin", 32'(fin), 0);
    end

    // 2. burst, pause, burst
    repeat (5) cycle(0, 1, 0, 0);
    check_val("t2_five", 32'(cnt), 5);
    repeat (2) cycle(0, 0, 0, 0);
    check_val("t2_hold", 32'(cnt), 5);
    repeat (18) cycle(0, 1, 0, 0);
    check_val("t2_23", 32'(cnt), 23);
    check_val("t2_fin", 32'(fin), 0);

    // 3. terminal count, then hold there
    cycle(1, 0, 0, 0);
    repeat (33) cycle(0, 1, 0, 0);
    check_val("t3_max", 32'(cnt), 33);
    check_val("t3_fin", 32'(fin), 1);
    repeat (3) cycle(0, 0, 0, 0);
    check_val("t3_hold_cnt", 32'(cnt), 33);
    check_val("t3_hold_fin", 32'(fin), 1);

    if (!SAT) begin
      // 4. wrap, then climb back to MAX
      cycle(0, 1, 0, 0);
      check_val("t4_wrap_cnt", 32'(cnt), 0);
      check_val("t4_wrap_fin", 32'(fin), 0);
      cycle(0, 1, 0, 0);
      check_val("t4_after", 32'(cnt), 1);
      repeat (32) cycle(0, 1, 0, 0);
      check_val("t4_remax", 32'(cnt), 33);
    end else begin
      // 5. saturate at MAX
      cycle(1, 0, 0, 0);
      for (int i = 1; i <= 40; i++) begin
        cycle(0, 1, 0, 0);
        if (i >= 33) begin
          check_val("t5_sat_cnt", 32'(cnt), 33);
          check_val("t5_sat_fin", 32'(fin), 1);
        end
      end
    end

    // 6. reset at terminal count with enable high
    cycle(1, 1, 0, 0);
    check_val("t6_rst_cnt", 32'(cnt), 0);
    check_val("t6_rst_fin", 32'(fin), 0);

    // 6b. MAX = 1 toggles, and reset at terminal count
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    check_val("t6b_one", 32'(cnt1), 1);
    check_val("t6b_fin_one", 32'(fin1), 1);
    cycle(0, 0, 0, 1);
    if (!SAT) begin
      check_val("t6b_zero", 32'(cnt1), 0);
      check_val("t6b_fin_zero", 32'(fin1), 0);
      cycle(0, 0, 0, 1);
    end
    cycle(0, 0, 1, 1);
    check_val("t6b_rst", 32'(cnt1), 0);
    check_val("t6b_rst_fin", 32'(fin1), 0);
    repeat (4) cycle(0, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/enable_wrap_counter.md
Name: enable_wrap_counter

Overview:
- Parameterised up-counter that counts enabled clock cycles from 0 to MAX_COUNTER_VALUE.
- Flags completion on finished_o.
- Used as a generic cycle/event counter (timeouts, frame dividers) inside larger control blocks.
- Single clock domain, fully synchronous.

Parameters:
- MAX_COUNTER_VALUE, default 33: terminal count, integer >= 1. Counter range is 0..MAX_COUNTER_VALUE inclusive.
- Derived localparam W = $clog2(MAX_COUNTER_VALUE + 1): counter width (6 for default). Not user-overridable.

Ports:
- clock_i  input  1  system clock; all state updates on rising edge.
- reset_i  input  1  reset; synchronous, active-high.
- enable_i  input  1  count enable; sampled on rising edge.
- finished_o  output  1  high while counter equals MAX_COUNTER_VALUE.
- counter_val_o  output  W  current count value.

Behaviour:
- One clock; reset is synchronous and active-high (reset_i, sampled on rising edge of clock_i).
- Reset: counter_val_o = 0, finished_o = 0 on the first rising edge with reset_i = 1. Reset has priority over enable_i.
- Count: on a rising edge with reset_i = 0 and enable_i = 1:
  - if count < MAX_COUNTER_VALUE, count <= count + 1;
  - if count == MAX_COUNTER_VALUE, count <= 0 (wrap).
- Hold: enable_i = 0 leaves the count unchanged. Enable may toggle on any cycle with no restart or side effect.
- finished_o = (count == MAX_COUNTER_VALUE). It is decoded combinationally from the registered count, so it is glitch-free relative to the clock and has zero latency versus counter_val_o.
  - Stays high as long as the count holds at MAX with enable low.
  - Drops the cycle after an enabled wrap.
- Latency: counter_val_o reflects an enabled edge immediately after that edge (1-cycle register latency).
- Arithmetic: unsigned, W bits. Increment never overflows W because MAX_COUNTER_VALUE < 2^W. Comparison is performed at width W.
- Reset mid-count, including at MAX: count returns to 0 and finished_o deasserts on that edge.
- Before the first reset the outputs are X in simulation. No initial values are relied upon.
- MAX_COUNTER_VALUE == 1: count toggles 0/1 on each enabled edge; finished_o mirrors count.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined: on an enabled edge at MAX_COUNTER_VALUE the count holds at MAX (no wrap). finished_o stays high until reset.
- Undefined (default): wrap to 0 as specified above.
- All other behaviour is identical in both modes.

Decomposition:
- No shared package is required. W is a local derived parameter.
- If a package is added, it holds only a width helper function (clog2-based) for users that size buses from MAX_COUNTER_VALUE.
- Single module; no sub-module is natural (one register plus a comparator).

Test Plan:
1. Reset: hold reset_i = 1 for 2 cycles with enable_i = 1 -> counter_val_o = 0, finished_o = 0 throughout.
2. Enable burst with pause:
   - release reset, enable for 5 edges -> count = 5;
   - enable low for 2 edges -> count stays 5;
   - enable for 18 edges -> count = 23, finished_o = 0.
3. Terminal count:
   - enable continuously from 0 for 33 edges -> count = 33, finished_o = 1;
   - drop enable for 3 edges -> finished_o stays 1, count 33.
4. Wrap (macro undefined): one more enabled edge at 33 -> count = 0, finished_o = 0. Next enabled edge -> count = 1.
5. Saturate (COUNTER_SATURATE_EN defined): 40 enabled edges from 0 -> count = 33, finished_o = 1 from edge 33 onward.
6. Reset at terminal: at count 33 assert reset_i with enable_i = 1 for 1 edge -> count = 0, finished_o = 0. Repeat with MAX_COUNTER_VALUE = 1 and confirm the 0/1 toggle.
